ripple_count_reader: RTL and testbench



---
 rtl/ripple_count_reader.sv | 132 +++++++++++++
 tb/tb_ripple_count_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_reader.sv
// Coherent clk-domain reader for an asynchronous up/down ripple counter.
// Optional forced capture on timeout when RCR_TIMEOUT_EN is defined.
module ripple_count_reader #(
  parameter int SIZE       = 4,
  parameter int STABLE_CNT = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] cnt_in,
  input  logic            up,
  input  logic            rd_req,
  output logic            rd_ack,
  output logic            busy,
  output logic [SIZE-1:0] count_out,
  output logic [SIZE-1:0] delta_out,
  output logic            err
);

  localparam int SW = $clog2(STABLE_CNT + 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

  state_t          state;
  logic [SIZE-1:0] sync_cnt_meta, sync_cnt;
  logic            sync_up_meta, sync_up;
  logic [SIZE-1:0] prev, last, delta_next;
  logic [SW-1:0]   stab;
  logic            same, stable_hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_cnt_meta <= '0;
      sync_cnt      <= '0;
      sync_up_meta  <= 1'b0;
      sync_up       <= 1'b0;
    end else begin
      sync_cnt_meta <= cnt_in;
      sync_cnt      <= sync_cnt_meta;
      sync_up_meta  <= up;
      sync_up       <= sync_up_meta;
    end
  end

  assign same       = (sync_cnt == prev);
  assign stable_hit = same && (stab == SW'(STABLE_CNT - 1));

  // NOTE: default assignment first so no path leaves delta_next unassigned (no latch).
  always_comb begin
    delta_next = last - sync_cnt;
    if (sync_up) delta_next = sync_cnt - last;
  end

`ifdef RCR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo;
  logic          tmo_hit;
  logic          err_q;
  assign tmo_hit = (tmo == TW'(TIMEOUT - 1));
  assign err     = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign err            = 1'b0;
`endif

  // NOTE: prev and stab are reset too although IDLE reloads them; it keeps reset state deterministic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ack    <= 1'b0;
      busy      <= 1'b0;
      count_out <= '0;
      delta_out <= '0;
      last      <= '0;
      prev      <= '0;
      stab      <= '0;
`ifdef RCR_TIMEOUT_EN
      tmo       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rd_ack <= 1'b0;
          if (rd_req) begin
            state <= SAMPLE;
            busy  <= 1'b1;
            prev  <= sync_cnt;
            stab  <= SW'(1);
`ifdef RCR_TIMEOUT_EN
            tmo   <= '0;
`endif
          end
        end
        SAMPLE: begin
          prev <= sync_cnt;
          stab <= same ? stab + SW'(1) : SW'(1);
`ifdef RCR_TIMEOUT_EN
          tmo  <= tmo + TW'(1);
`endif
          if (stable_hit) begin
            state     <= DONE;
            rd_ack    <= 1'b1;
            count_out <= sync_cnt;
            delta_out <= delta_next;
            last      <= sync_cnt;
`ifdef RCR_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (tmo_hit) begin
            // Never settled: take whatever is on the bus and flag it.
            state     <= DONE;
            rd_ack    <= 1'b1;
            count_out <= sync_cnt;
            delta_out <= delta_next;
            last      <= sync_cnt;
            err_q     <= 1'b1;
`endif
          end
        end
        DONE: begin
          rd_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_count_reader.sv
// Self-checking bench for ripple_count_reader: vector table plus scoreboard of expected captures.
// Covers reset, static reads, wrap, down counting, back-to-back, instability and reset mid-read.
module tb_ripple_count_reader;

  localparam int SIZE       = 4;
  localparam int STABLE_CNT = 2;
  localparam int TIMEOUT    = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [SIZE-1:0] cnt_in;
  logic            up;
  logic            rd_req;
  logic            rd_ack;
  logic            busy;
  logic [SIZE-1:0] count_out;
  logic [SIZE-1:0] delta_out;
  logic            err;

  ripple_count_reader #(
    .SIZE(SIZE), .STABLE_CNT(STABLE_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .up(up), .rd_req(rd_req),
    .rd_ack(rd_ack), .busy(busy), .count_out(count_out), .delta_out(delta_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SIZE-1:0] cnt;
    logic            up;
    logic [SIZE-1:0] exp_count;
    logic [SIZE-1:0] exp_delta;
  } vec_t;

  typedef struct {
    logic [SIZE-1:0] count;
    logic [SIZE-1:0] delta;
    logic            err;
    logic            chk_data;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [SIZE-1:0] c, input logic [SIZE-1:0] d,
                          input logic e, input logic chk);
    exp_t x;
    x.count = c; x.delta = d; x.err = e; x.chk_data = chk;
    sb_q.push_back(x);
  endtask

  // Scoreboard monitor: compares every rd_ack pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rd_ack) begin
      check("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: count_out=%0h with no read pending at %0t", count_out, $time);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        if (x.chk_data) begin
          check("count_out", {28'd0, count_out}, {28'd0, x.count});
          check("delta_out", {28'd0, delta_out}, {28'd0, x.delta});
        end
        check("err", {31'd0, err}, {31'd0, x.err});
      end
    end
    prev_ack = rd_ack;
  end

  // Settle, issue a one-cycle request, measure ack latency from E0 and check busy around it.
  task automatic do_read(input logic [SIZE-1:0] c, input logic u,
                         input logic [SIZE-1:0] ec, input logic [SIZE-1:0] ed);
    int lat;
    cnt_in = c;
    up     = u;
    repeat (3) tick();
    push_exp(ec, ed, 1'b0, 1'b1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("busy_after_e0", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!rd_ack && lat < 40) begin
      tick();
      lat++;
    end
    check("read_latency", lat, STABLE_CNT - 1);
    tick();
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("count_held", {28'd0, count_out}, {28'd0, ec});
  endtask

  initial begin
    int lat;
    int gap;
    vecs[0] = '{cnt: 4'h5, up: 1'b1, exp_count: 4'h5, exp_delta: 4'h5};
    vecs[1] = '{cnt: 4'h2, up: 1'b1, exp_count: 4'h2, exp_delta: 4'hD};
    vecs[2] = '{cnt: 4'hE, up: 1'b0, exp_count: 4'hE, exp_delta: 4'h4};
    vecs[3] = '{cnt: 4'hE, up: 1'b0, exp_count: 4'hE, exp_delta: 4'h0};
    vecs[4] = '{cnt: 4'hF, up: 1'b1, exp_count: 4'hF, exp_delta: 4'h1};
    vecs[5] = '{cnt: 4'h0, up: 1'b1, exp_count: 4'h0, exp_delta: 4'h1};
    vecs[6] = '{cnt: 4'h3, up: 1'b0, exp_count: 4'h3, exp_delta: 4'hD};
    vecs[7] = '{cnt: 4'h3, up: 1'b1, exp_count: 4'h3, exp_delta: 4'h0};

    // Reset state
    rst_n  = 1'b0;
    cnt_in = 4'hA;
    up     = 1'b1;
    rd_req = 1'b0;
    repeat (3) tick();
    check("rst_rd_ack", {31'd0, rd_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count_out", {28'd0, count_out}, 32'd0);
    check("rst_delta_out", {28'd0, delta_out}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven reads
    for (int i = 0; i < 8; i++)
      do_read(vecs[i].cnt, vecs[i].up, vecs[i].exp_count, vecs[i].exp_delta);

    // Back-to-back: rd_req held high re-triggers after each DONE (last = 3)
    cnt_in = 4'h7;
    up     = 1'b1;
    repeat (3) tick();
    push_exp(4'h7, 4'h4, 1'b0, 1'b1);
    push_exp(4'h7, 4'h0, 1'b0, 1'b1);
    rd_req = 1'b1;
    tick();
    lat = 0;
    while (!rd_ack && lat < 40) begin
      tick();
      lat++;
    end
    check("b2b_first_latency", lat, STABLE_CNT - 1);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!rd_ack && gap < 40);
    rd_req = 1'b0;
    check("b2b_ack_gap", gap, STABLE_CNT + 1);
    tick();
    tick();
    check("b2b_idle_busy", {31'd0, busy}, 32'd0);

    // Instability: cnt_in toggles every cycle around the request
`ifdef RCR_TIMEOUT_EN
    push_exp(4'h0, 4'h0, 1'b1, 1'b0);
    lat = -1;
    for (int i = 0; i < 28; i++) begin
      cnt_in = i[0] ? 4'h6 : 4'h9;
      rd_req = (i == 4);
      tick();
      if (rd_ack && lat < 0) lat = i - 4;
    end
    check("timeout_latency", lat, TIMEOUT);
`else
    for (int i = 0; i < 28; i++) begin
      cnt_in = i[0] ? 4'h6 : 4'h9;
      rd_req = (i == 4);
      tick();
      if (i > 4) begin
        check("unstable_no_ack", {31'd0, rd_ack}, 32'd0);
        check("unstable_busy", {31'd0, busy}, 32'd1);
      end
    end
    cnt_in = 4'h9;
    push_exp(4'h9, 4'h2, 1'b0, 1'b1);
    lat = 0;
    while (!rd_ack && lat < 40) begin
      tick();
      lat++;
    end
    check("settle_latency", lat, 2 + STABLE_CNT);
`endif
    rd_req = 1'b0;
    repeat (3) tick();

    // Reset asserted mid-read aborts it and clears last
    cnt_in = 4'hC;
    up     = 1'b1;
    repeat (3) tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort_rd_ack", {31'd0, rd_ack}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count_out", {28'd0, count_out}, 32'd0);
    check("abort_delta_out", {28'd0, delta_out}, 32'd0);
    rst_n = 1'b1;
    do_read(4'hC, 1'b1, 4'hC, 4'hC);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
